cal_seq: RTL and testbench

//  Control sequencer for the calibration datapath; it drives selA2D/selCoeff/selMult/enTmp.
//  On strt_cal it runs one conversion, then applies three coefficients in order:

---
 rtl/cal_pkg.sv | 19 +
 rtl/cal_seq_if.sv | 41 ++++
 rtl/cal_wdog.sv | 28 ++
 rtl/cal_seq.sv | 133 +++++++++++++
 tb/tb_cal_seq.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cal_pkg.sv
// Calibration sequencer shared types: FSM states and coefficient slots.
// Optional watchdog build macro: CAL_TIMEOUT_EN.
package cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNV,
    CNV_WT,
    OFS,
    GAIN,
    TRIM,
    DONE
  } calState_t;

  localparam logic [1:0] IDX_OFS  = 2'd0;
  localparam logic [1:0] IDX_GAIN = 2'd1;
  localparam logic [1:0] IDX_TRIM = 2'd2;

endpackage

// File: rtl/cal_seq_if.sv
// Sequencer bus: command, A2D, NV_MEM and datapath control.
// master = sequencer, slave = surrounding logic.
interface cal_seq_if #(
  parameter int CH_W = 3
);

  logic            strt_cal;
  logic [CH_W-1:0] chnnl;
  logic            cnv_cmplt;
  logic            nv_rdy;
  logic            strt_cnv;
  logic            nv_rd;
  logic [CH_W+1:0] nv_addr;
  logic            selA2D;
  logic            selCoeff;
  logic            selMult;
  logic            enTmp;
  logic            cal_vld;
  logic            done;
  logic            busy;
  logic            err;

  modport master (
    input  strt_cal, chnnl,
    input  cnv_cmplt, nv_rdy,
    output strt_cnv, nv_rd, nv_addr,
    output selA2D, selCoeff, selMult,
    output enTmp, cal_vld,
    output done, busy, err
  );

  modport slave (
    output strt_cal, chnnl,
    output cnv_cmplt, nv_rdy,
    input  strt_cnv, nv_rd, nv_addr,
    input  selA2D, selCoeff, selMult,
    input  enTmp, cal_vld,
    input  done, busy, err
  );

endinterface

// File: rtl/cal_wdog.sv
// Wait-state watchdog: counts while en, cleared on state change.
// Used only when CAL_TIMEOUT_EN is defined.
module cal_wdog #(
  parameter int TMO_CYC = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TMO_CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires in the TMO_CYC-th waiting cycle of a state.
  assign expired = en && (cnt == W'(TMO_CYC - 1));

endmodule

// File: rtl/cal_seq.sv
// Calibration control sequencer: conversion, then offset/gain/trim.
// Build macro CAL_TIMEOUT_EN adds the wait watchdog and err flag.
module cal_seq #(
  parameter int CH_W    = 3,
  parameter int TMO_CYC = 1023
) (
  input logic       clk,
  input logic       rst_n,
  cal_seq_if.master bus
);

  import cal_pkg::*;

  calState_t       state;
  logic [CH_W-1:0] chnl;
  logic            errQ;
  logic            inNv;
  logic            rdyHit;
  logic            expired;

  logic            strtCnv;
  logic            nvRd;
  logic [1:0]      idx;
  logic            selA;
  logic            selC;
  logic            selM;

  assign inNv = (state == OFS) ||
                (state == GAIN) ||
                (state == TRIM);

  assign rdyHit = inNv && bus.nv_rdy && !expired;

`ifdef CAL_TIMEOUT_EN
  logic tmoEn;
  logic leave;

  assign tmoEn = inNv || (state == CNV_WT);

  assign leave =
    ((state == IDLE) && bus.strt_cal) ||
    (state == CNV) ||
    ((state == CNV_WT) && bus.cnv_cmplt) ||
    rdyHit ||
    (state == DONE) ||
    expired;

  cal_wdog #(
    .TMO_CYC(TMO_CYC)
  ) uWdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (leave),
    .en     (tmoEn),
    .expired(expired)
  );
`else
  logic unusedTmo;
  assign unusedTmo = ^TMO_CYC;
  assign expired   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      chnl  <= '0;
      errQ  <= 1'b0;
    end else if (expired) begin
      state <= IDLE;
      errQ  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.strt_cal) begin
            state <= CNV;
            chnl  <= bus.chnnl;
            errQ  <= 1'b0;
          end
        end
        CNV:    state <= CNV_WT;
        CNV_WT: if (bus.cnv_cmplt) state <= OFS;
        OFS:    if (bus.nv_rdy) state <= GAIN;
        GAIN:   if (bus.nv_rdy) state <= TRIM;
        TRIM:   if (bus.nv_rdy) state <= DONE;
        DONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    strtCnv = 1'b0;
    nvRd    = 1'b0;
    idx     = IDX_OFS;
    selA    = 1'b0;
    selC    = 1'b0;
    selM    = 1'b0;
    unique case (1'b1)
      (state == CNV): strtCnv = 1'b1;
      (state == OFS): begin
        nvRd = 1'b1;
        idx  = IDX_OFS;
        selA = 1'b1;
        selC = 1'b1;
      end
      (state == GAIN): begin
        nvRd = 1'b1;
        idx  = IDX_GAIN;
        selC = 1'b1;
        selM = 1'b1;
      end
      (state == TRIM): begin
        nvRd = 1'b1;
        idx  = IDX_TRIM;
        selC = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.strt_cnv = strtCnv;
  assign bus.nv_rd    = nvRd;
  assign bus.nv_addr  = nvRd ? {chnl, idx} : '0;
  assign bus.selA2D   = selA;
  assign bus.selCoeff = selC;
  assign bus.selMult  = selM;
  assign bus.enTmp    = rdyHit;
  assign bus.cal_vld  = rdyHit && (state == TRIM);
  assign bus.done     = (state == DONE);
  assign bus.busy     = (state != IDLE) && (state != DONE);
  assign bus.err      = errQ;

endmodule

// File: tb/tb_cal_seq.sv
// Randomized bench for cal_seq with A2D / NV_MEM responders.
// Define CAL_TIMEOUT_EN to also exercise the watchdog.
module tb_cal_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cal_seq_if #(.CH_W(3)) bus();

  cal_seq #(
    .CH_W   (3),
    .TMO_CYC(15)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef CAL_TIMEOUT_EN
  localparam int MAXCNV = 12;
`else
  localparam int MAXCNV = 20;
`endif
  localparam int MAXC = 400;

  int errors = 0;
  int checks = 0;

  logic [11:0] a2dBus;
  logic [7:0]  coeffBus;
  logic [14:0] outVec;

  assign outVec = {bus.strt_cnv, bus.nv_rd, bus.nv_addr,
                   bus.selA2D, bus.selCoeff, bus.selMult,
                   bus.enTmp, bus.cal_vld, bus.done,
                   bus.busy, bus.err};

  int nStrtCnv, nEn, nVld, nDone, doneCyc, vldOnEn, errCyc;
  bit timedOut, addrUnstable, rdDropped, doneBusy, postBusy;
  bit zeroAfter, errBusy, errC0, errC1;
  logic [4:0]  addrQ[$];
  logic [2:0]  selQ[$];
  logic [31:0] tmp, expTmp;

  // mode: 0 normal, 1 strt_cal during GAIN, 2 reset in TRIM,
  // 3 NV_MEM silent in GAIN, 4 cnv_cmplt early in IDLE/CNV
  task automatic run_cal(input logic [2:0] ch, input int dCnv,
                         input int dNv, input int mode);
    int cnvCnt, nvWait, rstAt, post;
    bit fin;
    logic [4:0]  curAddr;
    logic [11:0] a2d;
    logic [7:0]  co;
    logic [7:0]  cq[$];
    nStrtCnv = 0; nEn = 0; nVld = 0; nDone = 0;
    doneCyc = -1; vldOnEn = -1; errCyc = -1;
    timedOut = 0; addrUnstable = 0; rdDropped = 0;
    doneBusy = 0; postBusy = 0; zeroAfter = 0; errBusy = 0;
    errC0 = 0; errC1 = 0;
    addrQ.delete(); selQ.delete();
    tmp = '0; expTmp = '1;
    a2d = 12'($urandom);
    cnvCnt = -1; nvWait = 0; rstAt = -1; post = -1;
    fin = 0; curAddr = '0;
    for (int c = 0; c < MAXC; c++) begin
      if (rstAt >= 0 && c == rstAt + 1) zeroAfter = (outVec === '0);
      if (c == 0) errC0 = bus.err;
      if (c == 1) errC1 = bus.err;
      if (bus.done) begin
        nDone++; doneCyc = c; doneBusy = bus.busy;
      end
      if (post >= 0 && bus.busy) postBusy = 1;
      if (bus.err && errCyc < 0) begin
        errCyc = c; errBusy = bus.busy;
      end
      bus.strt_cal = (c == 0) ||
        (mode == 1 && bus.nv_rd && bus.nv_addr[1:0] == 2'd1);
      bus.chnnl = (c == 0) ? ch : 3'($urandom);
      bus.cnv_cmplt = (mode == 4 && c <= 1);
      bus.nv_rdy = 1'b0;
      coeffBus = 8'($urandom);
      rst_n = 1'b1;
      if (bus.strt_cnv) begin
        nStrtCnv++; cnvCnt = 0; a2dBus = 12'($urandom);
      end else if (cnvCnt >= 0) begin
        cnvCnt++;
        if (cnvCnt == dCnv + 1) begin
          bus.cnv_cmplt = 1'b1; a2dBus = a2d; cnvCnt = -1;
        end
      end
      if (bus.nv_rd) begin
        nvWait++;
        if (nvWait == 1) begin
          curAddr = bus.nv_addr; addrQ.push_back(bus.nv_addr);
        end else if (bus.nv_addr !== curAddr) begin
          addrUnstable = 1;
        end
        if (mode == 2 && bus.nv_addr[1:0] == 2'd2 && rstAt < 0) begin
          rst_n = 1'b0; rstAt = c;
        end else if (!(mode == 3 && bus.nv_addr[1:0] == 2'd1) &&
                     nvWait == dNv + 2) begin
          co = 8'($urandom);
          bus.nv_rdy = 1'b1; coeffBus = co;
          cq.push_back(co); nvWait = 0;
        end
      end else if (nvWait != 0) begin
        rdDropped = 1; nvWait = 0;
      end
      #1;
      if (bus.enTmp) begin
        nEn++;
        selQ.push_back({bus.selA2D, bus.selCoeff, bus.selMult});
        if (bus.selMult) tmp = 32'(coeffBus) * tmp;
        else tmp = (bus.selA2D ? 32'(a2dBus) : tmp) + 32'(coeffBus);
      end
      if (bus.cal_vld) begin
        nVld++; vldOnEn = nEn;
      end
      if (nDone > 0 && post < 0) post = 0;
      else if (post >= 0) post++;
      if (post == 4) begin fin = 1; break; end
      if (mode == 2 && rstAt >= 0 && c == rstAt + 8) begin
        fin = 1; break;
      end
      if (mode == 3 && errCyc >= 0 && c == errCyc + 3) begin
        fin = 1; break;
      end
      @(posedge clk); #1;
    end
    timedOut = !fin;
    if (cq.size() == 3)
      expTmp = ((32'(a2d) + 32'(cq[0])) * 32'(cq[1])) + 32'(cq[2]);
    bus.strt_cal = 1'b0; bus.cnv_cmplt = 1'b0; bus.nv_rdy = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.strt_cal = 1'b0; bus.chnnl = 3'd7;
    bus.cnv_cmplt = 1'b0; bus.nv_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outVec !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", outVec);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    logic [4:0] ea;
    run_cal(3'd5, 0, 0, 0);
    checks++;
    if (timedOut !== 1'b0) begin
      errors++; $display("FAIL nom_timeout: got %0d want 0", timedOut);
    end
    checks++;
    if (nStrtCnv !== 1) begin
      errors++; $display("FAIL nom_strt_cnv: got %0d want 1", nStrtCnv);
    end
    checks++;
    if (addrQ.size() !== 3) begin
      errors++; $display("FAIL nom_addr_cnt: got %0d want 3", addrQ.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        ea = 5'h14 + 5'(i);
        checks++;
        if (addrQ[i] !== ea) begin
          errors++;
          $display("FAIL nom_addr%0d: got %h want %h", i, addrQ[i], ea);
        end
      end
    end
    checks++;
    if (selQ.size() !== 3) begin
      errors++; $display("FAIL nom_en_cnt: got %0d want 3", selQ.size());
    end else begin
      checks++;
      if (selQ[0] !== 3'b110) begin
        errors++; $display("FAIL nom_sel0: got %b want 110", selQ[0]);
      end
      checks++;
      if (selQ[1][0] !== 1'b1) begin
        errors++; $display("FAIL nom_sel1: got %b want xx1", selQ[1]);
      end
      checks++;
      if (selQ[2] !== 3'b010) begin
        errors++; $display("FAIL nom_sel2: got %b want 010", selQ[2]);
      end
    end
    checks++;
    if (nVld !== 1 || vldOnEn !== 3) begin
      errors++;
      $display("FAIL nom_vld: got n=%0d at=%0d want n=1 at=3", nVld, vldOnEn);
    end
    checks++;
    if (nDone !== 1 || doneCyc !== 9) begin
      errors++;
      $display("FAIL nom_done: got n=%0d cyc=%0d want n=1 cyc=9", nDone, doneCyc);
    end
    checks++;
    if (doneBusy !== 1'b0 || postBusy !== 1'b0) begin
      errors++;
      $display("FAIL nom_busy: got d=%0d p=%0d want 0 0", doneBusy, postBusy);
    end
    checks++;
    if (tmp !== expTmp) begin
      errors++; $display("FAIL nom_temp: got %0d want %0d", tmp, expTmp);
    end
    checks++;
    if (errC1 !== 1'b0) begin
      errors++; $display("FAIL nom_err: got %0d want 0", errC1);
    end
  endtask

  task automatic test_stall();
    int exp;
    run_cal(3'd2, MAXCNV, 5, 0);
    exp = 9 + MAXCNV + 15;
    checks++;
    if (addrUnstable !== 1'b0 || rdDropped !== 1'b0) begin
      errors++;
      $display("FAIL stall_rd_stable: got u=%0d d=%0d want 0 0", addrUnstable, rdDropped);
    end
    checks++;
    if (nEn !== 3) begin
      errors++; $display("FAIL stall_en_cnt: got %0d want 3", nEn);
    end
    checks++;
    if (doneCyc !== exp || timedOut !== 1'b0) begin
      errors++; $display("FAIL stall_done: got %0d want %0d", doneCyc, exp);
    end
    checks++;
    if (tmp !== expTmp) begin
      errors++; $display("FAIL stall_temp: got %0d want %0d", tmp, expTmp);
    end
  endtask

  task automatic test_random();
    logic [2:0] ch;
    int dc, dn, exp;
    logic [4:0] ea;
    for (int r = 0; r < 5; r++) begin
      ch = 3'($urandom);
      dc = $urandom_range(0, MAXCNV);
      dn = $urandom_range(0, 5);
      run_cal(ch, dc, dn, 0);
      exp = 9 + dc + 3 * dn;
      checks++;
      if (doneCyc !== exp || nDone !== 1) begin
        errors++;
        $display("FAIL rnd%0d_done: got %0d want %0d", r, doneCyc, exp);
      end
      checks++;
      if (tmp !== expTmp || nVld !== 1) begin
        errors++;
        $display("FAIL rnd%0d_temp: got %0d want %0d", r, tmp, expTmp);
      end
      checks++;
      if (addrQ.size() !== 3 || addrUnstable) begin
        errors++;
        $display("FAIL rnd%0d_addr_cnt: got %0d want 3", r, addrQ.size());
      end else begin
        for (int i = 0; i < 3; i++) begin
          ea = {ch, 2'(i)};
          checks++;
          if (addrQ[i] !== ea) begin
            errors++;
            $display("FAIL rnd%0d_addr%0d: got %h want %h", r, i, addrQ[i], ea);
          end
        end
      end
    end
  endtask

  task automatic test_restart_busy();
    run_cal(3'd6, 2, 3, 1);
    checks++;
    if (nDone !== 1 || postBusy !== 1'b0) begin
      errors++;
      $display("FAIL restart_done: got n=%0d busy=%0d want 1 0", nDone, postBusy);
    end
    checks++;
    if (doneCyc !== 9 + 2 + 9 || nStrtCnv !== 1) begin
      errors++; $display("FAIL restart_cyc: got %0d want 20", doneCyc);
    end
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 8; i++) begin
      bus.strt_cal = 1'b0;
      bus.nv_rdy = 1'($urandom);
      bus.cnv_cmplt = 1'($urandom);
      #1;
      checks++;
      if (outVec !== '0) begin
        errors++; $display("FAIL idle_noise%0d: got %h want 0", i, outVec);
      end
      @(posedge clk); #1;
    end
    bus.nv_rdy = 1'b0; bus.cnv_cmplt = 1'b0;
  endtask

  task automatic test_reset_trim();
    run_cal(3'd3, 1, 1, 2);
    checks++;
    if (zeroAfter !== 1'b1) begin
      errors++; $display("FAIL rst_trim_idle: got %0d want 1", zeroAfter);
    end
    checks++;
    if (nDone !== 0 || nVld !== 0) begin
      errors++;
      $display("FAIL rst_trim_abort: got done=%0d vld=%0d want 0 0", nDone, nVld);
    end
    run_cal(3'd4, 0, 0, 0);
    checks++;
    if (doneCyc !== 9 || tmp !== expTmp) begin
      errors++;
      $display("FAIL rst_trim_rerun: got cyc=%0d want 9", doneCyc);
    end
  endtask

  task automatic test_cnv_overlap();
    run_cal(3'd1, 3, 0, 4);
    checks++;
    if (doneCyc !== 12 || nDone !== 1) begin
      errors++; $display("FAIL cnv_overlap: got %0d want 12", doneCyc);
    end
    checks++;
    if (tmp !== expTmp) begin
      errors++; $display("FAIL cnv_overlap_temp: got %0d want %0d", tmp, expTmp);
    end
  endtask

`ifdef CAL_TIMEOUT_EN
  task automatic test_timeout();
    run_cal(3'd5, 0, 0, 3);
    checks++;
    if (errCyc !== 20 || errBusy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err: got cyc=%0d busy=%0d want 20 0", errCyc, errBusy);
    end
    checks++;
    if (nDone !== 0) begin
      errors++; $display("FAIL tmo_done: got %0d want 0", nDone);
    end
    run_cal(3'd5, 0, 0, 0);
    checks++;
    if (errC0 !== 1'b1 || errC1 !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear: got %0d%0d want 10", errC0, errC1);
    end
  endtask
`endif

  initial begin
    a2dBus = '0; coeffBus = '0;
    test_reset();
    test_nominal();
    test_stall();
    test_random();
    test_restart_busy();
    test_idle_noise();
    test_reset_trim();
    test_cnv_overlap();
`ifdef CAL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
